// File: rtl/seq_event_fsm_if.sv
// Handshake bundle for seq_event_fsm: qualified input code and clear in,
// Mealy flags, completion pulses and state visibility out.
interface seq_event_fsm_if #(
    parameter int IN_W = 4,
    parameter int LW   = 2
);
    logic            clear;
    logic            in_valid;
    logic [IN_W-1:0] in_code;
    logic            flag_up;
    logic            flag_side;
    logic            up_hit;
    logic            tail_done;
    logic [1:0]      mode;
    logic [LW-1:0]   level;

    modport master (
        output clear, in_valid, in_code,
        input  flag_up, flag_side, up_hit, tail_done, mode, level
    );

    modport slave (
        input  clear, in_valid, in_code,
        output flag_up, flag_side, up_hit, tail_done, mode, level
    );
endinterface

// File: rtl/seq_event_fsm.sv
// Sequence-counting FSM walking up, side and tail chains of configurable depth,
// with Mealy top-of-chain flags and registered completion pulses.
module seq_event_fsm #(
    parameter int              IN_W       = 4,
    parameter int              UP_DEPTH   = 3,
    parameter int              SIDE_DEPTH = 3,
    parameter int              TAIL_DEPTH = 3,
    parameter logic [IN_W-1:0] UP_CODE    = IN_W'(4'b0111),
    parameter logic [IN_W-1:0] UP_MASK    = IN_W'(4'b0111),
    parameter logic [IN_W-1:0] SIDE_CODE  = IN_W'(4'b1011),
    parameter logic [IN_W-1:0] SIDE_MASK  = IN_W'(4'b1111),
    parameter logic [IN_W-1:0] BACK_CODE  = IN_W'(4'b0011),
    parameter logic [IN_W-1:0] BACK_MASK  = IN_W'(4'b1111)
) (
    input logic            clock,
    input logic            reset,
    seq_event_fsm_if.slave bus
);
    localparam int MAX_UT    = (UP_DEPTH > TAIL_DEPTH) ? UP_DEPTH : TAIL_DEPTH;
    localparam int MAX_DEPTH = (MAX_UT > SIDE_DEPTH) ? MAX_UT : SIDE_DEPTH;
    localparam int LW        = $clog2(MAX_DEPTH + 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_SIDE = 2'b01;
    localparam logic [1:0] MODE_TAIL = 2'b10;

    localparam logic [LW-1:0] ZERO     = '0;
    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [LW-1:0] UP_TOP   = LW'(UP_DEPTH);
    localparam logic [LW-1:0] SIDE_TOP = LW'(SIDE_DEPTH);
    localparam logic [LW-1:0] TAIL_TOP = LW'(TAIL_DEPTH);

    logic [1:0]    mode_q, mode_d;
    logic [LW-1:0] level_q, level_d;
    logic          up_hit_q, up_hit_d;
    logic          tail_done_q, tail_done_d;
    logic          match_up, match_side, match_back;
    logic          cls_up, cls_side, cls_back;
    logic          legal;

    // Invalid cycles classify as "other"; priority is BACK > SIDE > UP.
    assign match_up   = (bus.in_code & UP_MASK)   == (UP_CODE & UP_MASK);
    assign match_side = (bus.in_code & SIDE_MASK) == (SIDE_CODE & SIDE_MASK);
    assign match_back = (bus.in_code & BACK_MASK) == (BACK_CODE & BACK_MASK);
    assign cls_back   = bus.in_valid && match_back;
    assign cls_side   = bus.in_valid && match_side && !match_back;
    assign cls_up     = bus.in_valid && match_up && !match_side && !match_back;

    always_comb begin
        legal = 1'b0;
        case (mode_q)
            MODE_UP:   legal = (level_q <= UP_TOP);
            MODE_SIDE: legal = (level_q >= ONE) && (level_q <= SIDE_TOP);
            MODE_TAIL: legal = (level_q >= ONE) && (level_q <= TAIL_TOP);
            default:   legal = 1'b0;
        endcase
    end

    assign bus.flag_up   = legal && (mode_q == MODE_UP) && (level_q == UP_TOP)
                           && !cls_back && !cls_side;
    assign bus.flag_side = legal && (mode_q == MODE_SIDE) && (level_q == SIDE_TOP)
                           && !cls_back && !cls_up;

    always_comb begin
        mode_d      = mode_q;
        level_d     = level_q;
        up_hit_d    = 1'b0;
        tail_done_d = 1'b0;
        if (!legal) begin
            mode_d  = MODE_UP;
            level_d = ZERO;
        end else begin
            case (mode_q)
                MODE_UP: begin
                    if (cls_up) begin
                        if (level_q != UP_TOP) level_d = level_q + ONE;
                        // Only the climb from one below the top counts as entry.
                        up_hit_d = (level_q == UP_TOP - ONE);
                    end else if (cls_side) begin
                        mode_d  = MODE_SIDE;
                        level_d = ONE;
                    end else if (cls_back) begin
                        if (level_q == UP_TOP) begin
                            mode_d  = MODE_TAIL;
                            level_d = ONE;
                        end else if (level_q != ZERO) begin
                            level_d = level_q - ONE;
                        end
                    end
                end
                MODE_SIDE: begin
                    if (cls_side) begin
                        if (level_q != SIDE_TOP) level_d = level_q + ONE;
                    end else if (cls_up) begin
                        mode_d  = MODE_UP;
                        level_d = ONE;
                    end else if (cls_back) begin
                        if (level_q == ONE) begin
                            mode_d  = MODE_UP;
                            level_d = ZERO;
                        end else if (level_q == SIDE_TOP) begin
                            mode_d  = MODE_TAIL;
                            level_d = ONE;
                        end else begin
                            level_d = level_q - ONE;
                        end
                    end
                end
                MODE_TAIL: begin
                    if (cls_back) begin
                        if (level_q == TAIL_TOP) begin
                            mode_d      = MODE_UP;
                            level_d     = ZERO;
                            tail_done_d = 1'b1;
                        end else begin
                            level_d = level_q + ONE;
                        end
                    end else if (cls_up) begin
                        mode_d  = MODE_UP;
                        level_d = ONE;
                    end else if (cls_side) begin
                        mode_d  = MODE_SIDE;
                        level_d = ONE;
                    end
                end
                default: begin
                    mode_d  = MODE_UP;
                    level_d = ZERO;
                end
            endcase
        end
        if (bus.clear) begin
            mode_d      = MODE_UP;
            level_d     = ZERO;
            up_hit_d    = 1'b0;
            tail_done_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_UP;
            level_q     <= ZERO;
            up_hit_q    <= 1'b0;
            tail_done_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            level_q     <= level_d;
            up_hit_q    <= up_hit_d;
            tail_done_q <= tail_done_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.level     = level_q;
    assign bus.up_hit    = up_hit_q;
    assign bus.tail_done = tail_done_q;
endmodule

// File: tb/tb_seq_event_fsm.sv
// Bench for seq_event_fsm: directed chain scenarios plus randomized traffic
// against a rule-level reference model, on a default and a deep-up build.
module tb_seq_event_fsm;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seq_event_fsm_if #(.IN_W(4), .LW(2)) if0 ();
    seq_event_fsm_if #(.IN_W(4), .LW(3)) if1 ();

    seq_event_fsm dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
    seq_event_fsm #(.UP_DEPTH(5), .TAIL_DEPTH(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=UP 1=SIDE 2=TAIL, level as plain integer.
    int up_d[2]   = '{3, 5};
    int side_d[2] = '{3, 3};
    int tail_d[2] = '{3, 1};
    int m_mode[2];
    int m_level[2];
    bit m_hit[2];
    bit m_done[2];
    bit e_fu, e_fs;

    logic [1:0] o_mode;
    logic [7:0] o_level;
    logic       o_hit, o_done, o_fu, o_fs;
    logic       pre_fu, pre_fs;
    logic [3:0] codes[5] = '{4'b0111, 4'b1011, 4'b0011, 4'b0000, 4'b1111};

    function automatic int classify(input bit v, input logic [3:0] c);
        if (!v) return 0;
        if (c == 4'b0011) return 3;
        if (c == 4'b1011) return 2;
        if ((c & 4'b0111) == 4'b0111) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_level[d] = 0; m_hit[d] = 0; m_done[d] = 0;
        end
    endfunction

    function automatic void model_flags(input int d, input bit v, input logic [3:0] c);
        int k = classify(v, c);
        e_fu = (m_mode[d] == 0) && (m_level[d] == up_d[d]) && (k != 2) && (k != 3);
        e_fs = (m_mode[d] == 1) && (m_level[d] == side_d[d]) && (k != 1) && (k != 3);
    endfunction

    function automatic void model_step(input int d, input bit v, input logic [3:0] c, input bit clr);
        int k = classify(v, c);
        m_hit[d] = 0; m_done[d] = 0;
        if (clr) begin m_mode[d] = 0; m_level[d] = 0; return; end
        if (k == 0) return;
        if (m_mode[d] == 0) begin
            if (k == 1) begin
                if (m_level[d] < up_d[d]) begin
                    m_level[d]++;
                    m_hit[d] = (m_level[d] == up_d[d]);
                end
            end else if (k == 2) begin
                m_mode[d] = 1; m_level[d] = 1;
            end else if (m_level[d] == up_d[d]) begin
                m_mode[d] = 2; m_level[d] = 1;
            end else if (m_level[d] > 0) begin
                m_level[d]--;
            end
        end else if (m_mode[d] == 1) begin
            if (k == 2) begin
                if (m_level[d] < side_d[d]) m_level[d]++;
            end else if (k == 1) begin
                m_mode[d] = 0; m_level[d] = 1;
            end else if (m_level[d] == side_d[d]) begin
                m_mode[d] = 2; m_level[d] = 1;
            end else begin
                m_level[d]--;
                if (m_level[d] == 0) m_mode[d] = 0;
            end
        end else begin
            if (k == 3) begin
                if (m_level[d] == tail_d[d]) begin
                    m_mode[d] = 0; m_level[d] = 0; m_done[d] = 1;
                end else begin
                    m_level[d]++;
                end
            end else if (k == 1) begin
                m_mode[d] = 0; m_level[d] = 1;
            end else if (k == 2) begin
                m_mode[d] = 1; m_level[d] = 1;
            end
        end
    endfunction

    task automatic drive(input int d, input bit v, input logic [3:0] c, input bit clr);
        if (d == 0) begin
            if0.in_valid = v; if0.in_code = c; if0.clear = clr;
        end else begin
            if1.in_valid = v; if1.in_code = c; if1.clear = clr;
        end
    endtask

    task automatic sample(input int d);
        if (d == 0) begin
            o_mode = if0.mode; o_level = 8'(if0.level); o_hit = if0.up_hit;
            o_done = if0.tail_done; o_fu = if0.flag_up; o_fs = if0.flag_side;
        end else begin
            o_mode = if1.mode; o_level = 8'(if1.level); o_hit = if1.up_hit;
            o_done = if1.tail_done; o_fu = if1.flag_up; o_fs = if1.flag_side;
        end
    endtask

    // One clocked transaction: flags captured before the edge, state after it.
    task automatic apply(input int d, input bit v, input logic [3:0] c, input bit clr);
        drive(d, v, c, clr);
        #1;
        sample(d);
        pre_fu = o_fu; pre_fs = o_fs;
        model_flags(d, v, c);
        @(posedge clock);
        model_step(d, v, c, clr);
        #1;
        drive(d, 1'b0, 4'b0000, 1'b0);
        sample(d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            n_checks++;
            if (o_mode !== 2'b00 || o_level !== 8'd0 || o_hit !== 1'b0 || o_done !== 1'b0 ||
                o_fu !== 1'b0 || o_fs !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: mode=%b level=%0d up_hit=%b tail_done=%b flag_up=%b flag_side=%b, expected all zero",
                         d, o_mode, o_level, o_hit, o_done, o_fu, o_fs);
            end
        end
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        apply(0, 1'b0, 4'b0111, 1'b0);
        n_checks++;
        if (o_mode !== 2'b00 || o_level !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle: mode=%b level=%0d, expected mode=00 level=0", o_mode, o_level);
        end
    endtask

    task automatic test_up_chain();
        for (int i = 1; i <= 3; i++) begin
            apply(0, 1'b1, 4'b0111, 1'b0);
            n_checks++;
            if (o_mode !== 2'b00 || o_level !== 8'(i) || o_hit !== (i == 3)) begin
                n_fail++;
                $display("FAIL up_chain step %0d: mode=%b level=%0d up_hit=%b, expected mode=00 level=%0d up_hit=%b",
                         i, o_mode, o_level, o_hit, i, (i == 3));
            end
        end
        apply(0, 1'b1, 4'b0000, 1'b0);
        n_checks++;
        if (pre_fu !== 1'b1 || o_level !== 8'd3 || o_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL up_top_other: flag_up=%b level=%0d up_hit=%b, expected 1 3 0", pre_fu, o_level, o_hit);
        end
        apply(0, 1'b1, 4'b0111, 1'b0);
        n_checks++;
        if (pre_fu !== 1'b1 || o_level !== 8'd3 || o_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL up_saturate: flag_up=%b level=%0d up_hit=%b, expected 1 3 0", pre_fu, o_level, o_hit);
        end
        drive(0, 1'b1, 4'b1011, 1'b0);
        #1;
        sample(0);
        n_checks++;
        if (o_fu !== 1'b0) begin
            n_fail++;
            $display("FAIL up_top_side_flag: flag_up=%b, expected 0", o_fu);
        end
        drive(0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_tail();
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1'b1, 4'b0011, 1'b0);
            n_checks++;
            if (o_mode !== ((i == 4) ? 2'b00 : 2'b10) || o_level !== ((i == 4) ? 8'd0 : 8'(i)) ||
                o_done !== (i == 4)) begin
                n_fail++;
                $display("FAIL tail step %0d: mode=%b level=%0d tail_done=%b", i, o_mode, o_level, o_done);
            end
        end
        apply(0, 1'b0, 4'b0000, 1'b0);
        n_checks++;
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tail_pulse_width: tail_done=%b, expected 0", o_done);
        end
    endtask

    task automatic test_side();
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1'b1, 4'b1011, 1'b0);
            n_checks++;
            if (o_mode !== 2'b01 || o_level !== 8'((i > 3) ? 3 : i) || pre_fs !== (i == 4)) begin
                n_fail++;
                $display("FAIL side step %0d: mode=%b level=%0d flag_side=%b", i, o_mode, o_level, pre_fs);
            end
        end
        for (int j = 0; j < 3; j++) begin
            drive(0, 1'b1, codes[j + 2 - ((j == 2) ? 4 : 0)], 1'b0);
            #1;
            sample(0);
            n_checks++;
            if (o_fs !== (j == 1)) begin
                n_fail++;
                $display("FAIL side_flag code %b: flag_side=%b, expected %b", if0.in_code, o_fs, (j == 1));
            end
        end
        apply(0, 1'b1, 4'b0011, 1'b0);
        n_checks++;
        if (o_mode !== 2'b10 || o_level !== 8'd1) begin
            n_fail++;
            $display("FAIL side_top_back: mode=%b level=%0d, expected 10 1", o_mode, o_level);
        end
        for (int i = 0; i < 3; i++) apply(0, 1'b1, 4'b0011, 1'b0);
        apply(0, 1'b1, 4'b1011, 1'b0);
        apply(0, 1'b1, 4'b1011, 1'b0);
        apply(0, 1'b1, 4'b0011, 1'b0);
        n_checks++;
        if (o_mode !== 2'b01 || o_level !== 8'd1) begin
            n_fail++;
            $display("FAIL side_back_mid: mode=%b level=%0d, expected 01 1", o_mode, o_level);
        end
        apply(0, 1'b1, 4'b0011, 1'b0);
        n_checks++;
        if (o_mode !== 2'b00 || o_level !== 8'd0) begin
            n_fail++;
            $display("FAIL side_back_bottom: mode=%b level=%0d, expected 00 0", o_mode, o_level);
        end
    endtask

    task automatic test_up_back();
        apply(0, 1'b1, 4'b0111, 1'b0);
        apply(0, 1'b1, 4'b0111, 1'b0);
        for (int i = 1; i >= -1; i--) begin
            apply(0, 1'b1, 4'b0011, 1'b0);
            n_checks++;
            if (o_mode !== 2'b00 || o_level !== 8'((i < 0) ? 0 : i)) begin
                n_fail++;
                $display("FAIL up_back to %0d: mode=%b level=%0d", (i < 0) ? 0 : i, o_mode, o_level);
            end
        end
        apply(0, 1'b0, 4'b0111, 1'b0);
        n_checks++;
        if (o_mode !== 2'b00 || o_level !== 8'd0 || o_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_hold: mode=%b level=%0d up_hit=%b, expected 00 0 0", o_mode, o_level, o_hit);
        end
    endtask

    task automatic test_clear();
        for (int t = 2; t <= 3; t++) begin
            for (int i = 0; i < 3; i++) apply(0, 1'b1, 4'b0111, 1'b0);
            for (int i = 0; i < t; i++) apply(0, 1'b1, 4'b0011, 1'b0);
            apply(0, 1'b1, 4'b0011, 1'b1);
            n_checks++;
            if (o_mode !== 2'b00 || o_level !== 8'd0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_in_tail%0d: mode=%b level=%0d tail_done=%b, expected 00 0 0",
                         t, o_mode, o_level, o_done);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) apply(0, 1'b1, 4'b1011, 1'b0);
        drive(0, 1'b1, 4'b0000, 1'b0);
        #1;
        sample(0);
        n_checks++;
        if (o_fs !== 1'b1) begin
            n_fail++;
            $display("FAIL side_top_flag: flag_side=%b, expected 1", o_fs);
        end
        #1 reset = 1'b1;
        #1;
        sample(0);
        n_checks++;
        if (o_fs !== 1'b0 || o_mode !== 2'b00 || o_level !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_side: flag_side=%b mode=%b level=%0d, expected 0 00 0", o_fs, o_mode, o_level);
        end
        #1 reset = 1'b0;
        model_reset();
        drive(0, 1'b0, 4'b0000, 1'b0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) apply(0, 1'b1, 4'b0111, 1'b0);
        #1 reset = 1'b1;
        #1;
        sample(0);
        n_checks++;
        if (o_hit !== 1'b0 || o_level !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_pulse: up_hit=%b level=%0d, expected 0 0", o_hit, o_level);
        end
        #1 reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_deep();
        for (int i = 1; i <= 5; i++) begin
            apply(1, 1'b1, 4'b0111, 1'b0);
            n_checks++;
            if (o_mode !== 2'b00 || o_level !== 8'(i) || o_hit !== (i == 5)) begin
                n_fail++;
                $display("FAIL deep_up step %0d: mode=%b level=%0d up_hit=%b", i, o_mode, o_level, o_hit);
            end
        end
        apply(1, 1'b1, 4'b0011, 1'b0);
        n_checks++;
        if (o_mode !== 2'b10 || o_level !== 8'd1 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL deep_tail_entry: mode=%b level=%0d tail_done=%b, expected 10 1 0", o_mode, o_level, o_done);
        end
        apply(1, 1'b1, 4'b0011, 1'b0);
        n_checks++;
        if (o_mode !== 2'b00 || o_level !== 8'd0 || o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL deep_tail_exit: mode=%b level=%0d tail_done=%b, expected 00 0 1", o_mode, o_level, o_done);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [3:0] c;
        bit v, clr;
        int sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 5);
            c   = (sel == 5) ? 4'($urandom) : codes[sel];
            v   = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            apply(d, v, c, clr);
            n_checks++;
            if (pre_fu !== e_fu || pre_fs !== e_fs) begin
                n_fail++;
                $display("FAIL rnd_flags dut%0d cyc %0d: flag_up=%b flag_side=%b, expected %b %b",
                         d, i, pre_fu, pre_fs, e_fu, e_fs);
            end
            n_checks++;
            if (o_mode !== 2'(m_mode[d]) || o_level !== 8'(m_level[d]) || o_hit !== m_hit[d] ||
                o_done !== m_done[d]) begin
                n_fail++;
                $display("FAIL rnd_state dut%0d cyc %0d: mode=%b level=%0d up_hit=%b tail_done=%b, expected %0d %0d %b %b",
                         d, i, o_mode, o_level, o_hit, o_done, m_mode[d], m_level[d], m_hit[d], m_done[d]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 4'b0000, 1'b0);
        drive(1, 1'b0, 4'b0000, 1'b0);
        #2;
        test_reset();
        test_up_chain();
        test_tail();
        test_side();
        test_up_back();
        test_clear();
        test_async_reset();
        test_deep();
        test_random(0, 400);
        test_random(1, 400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
